// File: rtl/rpspmc_readback_pkg.sv
// Shared definitions for the RPSPMC monitor readback path: special module
// addresses, version words, FSM and decode enums, channel-slice helper.
package rpspmc_readback_pkg;

  localparam int unsigned DEF_NUM_CH            = 8;
  localparam int unsigned DEF_DATA_W            = 32;
  localparam int unsigned DEF_BASE_ADDR         = 100001;
  localparam int unsigned DEF_TIMING_TEST_ADDR  = 101999;
  localparam int unsigned DEF_TIMING_RESET_ADDR = 102000;
  localparam int unsigned DEF_VERSION_ADDR      = 199997;
  localparam logic [31:0] DEF_VERSION_A         = 32'hEC01_0100;
  localparam logic [31:0] DEF_VERSION_B         = 32'h2025_0301;

  // Snapshot FSM: LIVE refreshes every cycle, CAPTURE loads once, HELD freezes.
  typedef enum logic [1:0] {
    LIVE    = 2'd0,
    CAPTURE = 2'd1,
    HELD    = 2'd2
  } snap_state_e;

  // What the registered address currently selects.
  typedef enum logic [2:0] {
    SEL_NONE    = 3'd0,
    SEL_CHAN    = 3'd1,
    SEL_TEST    = 3'd2,
    SEL_RESET   = 3'd3,
    SEL_VERSION = 3'd4
  } sel_kind_e;

  // LSB position of channel k inside a packed NUM_CH*w bus.
  function automatic int unsigned ch_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

  // Width of a channel index; never zero so single-channel builds stay legal.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/readback_addr_decode.sv
// Stage 1 of the readback pipeline: registers the host address twice and
// decodes the newer copy into a selection kind plus channel index.
module readback_addr_decode
  import rpspmc_readback_pkg::*;
#(
  parameter int unsigned NUM_CH            = DEF_NUM_CH,
  parameter int unsigned BASE_ADDR         = DEF_BASE_ADDR,
  parameter int unsigned TIMING_TEST_ADDR  = DEF_TIMING_TEST_ADDR,
  parameter int unsigned TIMING_RESET_ADDR = DEF_TIMING_RESET_ADDR,
  parameter int unsigned VERSION_ADDR      = DEF_VERSION_ADDR,
  parameter int unsigned CH_W              = idx_w(NUM_CH)
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic [31:0]     config_addr,
  input  logic            hold_prev,
  output sel_kind_e       sel_kind,
  output logic [CH_W-1:0] chan_idx,
  output logic            snap_flag,
  output logic            addr_change
);

  logic [31:0] addr_q;
  logic [31:0] addr_qq;
  logic [30:0] mod_addr;
  logic [30:0] idx;

  // Address pipeline; addr_qq is parked while a capture is in flight so an
  // address change arriving during CAPTURE is still visible in HELD.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      addr_q  <= '0;
      addr_qq <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values, regardless of statement order.
      addr_q <= config_addr;
      if (!hold_prev) begin
        addr_qq <= addr_q;
      end
    end
  end

  // Decode the registered address; special addresses win over the window.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    mod_addr = addr_q[30:0];
    idx      = mod_addr - 31'(BASE_ADDR);
    chan_idx = idx[CH_W-1:0];
    sel_kind = SEL_NONE;
    if (mod_addr == 31'(TIMING_RESET_ADDR)) begin
      sel_kind = SEL_RESET;
    end else if (mod_addr == 31'(TIMING_TEST_ADDR)) begin
      sel_kind = SEL_TEST;
    end else if (mod_addr == 31'(VERSION_ADDR)) begin
      sel_kind = SEL_VERSION;
    end else if (idx < 31'(NUM_CH)) begin
      sel_kind = SEL_CHAN;
    end
  end

  assign snap_flag   = addr_q[31];
  assign addr_change = (addr_q != addr_qq);

endmodule

// File: rtl/readback_mux_snapshot.sv
// Readback mux between the RPSPMC monitor taps and the AXI-GPIO pair:
// two-stage address decode, coherent A/B selection, timing counter and a
// host-triggered snapshot/hold mode with a wrapping capture counter.
module readback_mux_snapshot
  import rpspmc_readback_pkg::*;
#(
  parameter int unsigned NUM_CH            = DEF_NUM_CH,
  parameter int unsigned DATA_W            = DEF_DATA_W,
  parameter int unsigned BASE_ADDR         = DEF_BASE_ADDR,
  parameter int unsigned TIMING_TEST_ADDR  = DEF_TIMING_TEST_ADDR,
  parameter int unsigned TIMING_RESET_ADDR = DEF_TIMING_RESET_ADDR,
  parameter int unsigned VERSION_ADDR      = DEF_VERSION_ADDR,
  parameter logic [31:0] VERSION_A         = DEF_VERSION_A,
  parameter logic [31:0] VERSION_B         = DEF_VERSION_B
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [31:0]              config_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_a,
  input  logic [NUM_CH*DATA_W-1:0] ch_b,
  output logic [DATA_W-1:0]        gpio_dataA,
  output logic [DATA_W-1:0]        gpio_dataB,
  output logic                     snap_valid,
  output logic [15:0]              snap_count,
  output logic                     addr_hit
);

  localparam int unsigned CH_W = idx_w(NUM_CH);

  localparam bit TEST_IN_WIN  = (TIMING_TEST_ADDR  >= BASE_ADDR) && (TIMING_TEST_ADDR  < BASE_ADDR + NUM_CH);
  localparam bit RESET_IN_WIN = (TIMING_RESET_ADDR >= BASE_ADDR) && (TIMING_RESET_ADDR < BASE_ADDR + NUM_CH);
  localparam bit VER_IN_WIN   = (VERSION_ADDR      >= BASE_ADDR) && (VERSION_ADDR      < BASE_ADDR + NUM_CH);

  // A special address inside the channel window would shadow a channel.
  if (TEST_IN_WIN || RESET_IN_WIN || VER_IN_WIN) begin : g_bad_window
    $error("readback_mux_snapshot: channel window overlaps a special address");
  end
  // Tick and version words are 32 bits wide and must fit the output.
  if (DATA_W < 32) begin : g_bad_width
    $error("readback_mux_snapshot: DATA_W must be at least 32");
  end

  sel_kind_e       sel_kind;
  logic [CH_W-1:0] chan_idx;
  logic            snap_flag;
  logic            addr_change;
  logic            hold_prev;

  snap_state_e     state;
  snap_state_e     state_d;
  logic            load_out;
  logic            do_capture;
  logic            snap_valid_d;

  logic [31:0]       tick;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic              sel_hit;

  readback_addr_decode #(
    .NUM_CH            (NUM_CH),
    .BASE_ADDR         (BASE_ADDR),
    .TIMING_TEST_ADDR  (TIMING_TEST_ADDR),
    .TIMING_RESET_ADDR (TIMING_RESET_ADDR),
    .VERSION_ADDR      (VERSION_ADDR),
    .CH_W              (CH_W)
  ) u_decode (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .config_addr (config_addr),
    .hold_prev   (hold_prev),
    .sel_kind    (sel_kind),
    .chan_idx    (chan_idx),
    .snap_flag   (snap_flag),
    .addr_change (addr_change)
  );

  // Free-running timing counter, held at zero while the reset address is decoded.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tick <= '0;
    end else if (sel_kind == SEL_RESET) begin
      tick <= '0;
    end else begin
      tick <= tick + 32'd1;
    end
  end

  // Next output words; A and B of a channel come from the same select.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_hit = 1'b1;
    unique case (sel_kind)
      SEL_CHAN: begin
        for (int k = 0; k < int'(NUM_CH); k++) begin
          if (chan_idx == CH_W'(k)) begin
            sel_a = ch_a[ch_lsb(k, DATA_W) +: DATA_W];
            sel_b = ch_b[ch_lsb(k, DATA_W) +: DATA_W];
          end
        end
      end
      SEL_RESET: begin
        sel_a = '0;
        sel_b = '0;
      end
      SEL_TEST: begin
        sel_a = DATA_W'(tick);
        sel_b = gpio_dataA;
      end
      SEL_VERSION: begin
        sel_a = DATA_W'(VERSION_A);
        sel_b = DATA_W'(VERSION_B);
      end
      default: begin
        // Unmapped: liveness pattern so the host can see the link ticking.
        sel_a   = gpio_dataA + DATA_W'(1);
        sel_b   = gpio_dataA + DATA_W'(13);
        sel_hit = 1'b0;
      end
    endcase
  end

  // Snapshot FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= LIVE;
    end else begin
      state <= state_d;
    end
  end

  // Snapshot FSM next state and output-load controls.
  always_comb begin
    state_d      = state;
    load_out     = 1'b0;
    do_capture   = 1'b0;
    snap_valid_d = snap_valid;
    hold_prev    = 1'b0;
    unique case (state)
      LIVE: begin
        load_out     = 1'b1;
        snap_valid_d = 1'b0;
        if (addr_change && snap_flag) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        load_out     = 1'b1;
        do_capture   = 1'b1;
        snap_valid_d = 1'b1;
        hold_prev    = 1'b1;
        state_d      = HELD;
      end
      HELD: begin
        if (addr_change) begin
          if (snap_flag) begin
            state_d = CAPTURE;
          end else begin
            // Leave hold with live data and snap_valid low on the same edge.
            state_d      = LIVE;
            load_out     = 1'b1;
            snap_valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = LIVE;
      end
    endcase
  end

  // Output registers and capture counter.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      gpio_dataA <= '0;
      gpio_dataB <= '0;
      addr_hit   <= 1'b0;
      snap_valid <= 1'b0;
      snap_count <= '0;
    end else begin
      if (load_out) begin
        gpio_dataA <= sel_a;
        gpio_dataB <= sel_b;
        addr_hit   <= sel_hit;
      end
      snap_valid <= snap_valid_d;
      if (do_capture) begin
        snap_count <= snap_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_readback_mux_snapshot.sv
// Directed bench for readback_mux_snapshot with a cycle-stamped scoreboard.
module tb_readback_mux_snapshot;

  localparam int unsigned NCH  = 8;
  localparam int unsigned DW   = 32;
  localparam logic [31:0] RAMP = 32'h5000_0000;
  localparam logic [31:0] VA   = 32'hEC01_0100;
  localparam logic [31:0] VB   = 32'h2025_0301;

  logic              aclk;
  logic              aresetn;
  logic [31:0]       config_addr;
  logic [NCH*DW-1:0] ch_a;
  logic [NCH*DW-1:0] ch_b;
  logic [DW-1:0]     gpio_dataA;
  logic [DW-1:0]     gpio_dataB;
  logic              snap_valid;
  logic [15:0]       snap_count;
  logic              addr_hit;

  readback_mux_snapshot dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .config_addr (config_addr),
    .ch_a        (ch_a),
    .ch_b        (ch_b),
    .gpio_dataA  (gpio_dataA),
    .gpio_dataB  (gpio_dataB),
    .snap_valid  (snap_valid),
    .snap_count  (snap_count),
    .addr_hit    (addr_hit)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    string       tag;
    int unsigned due;
    logic [81:0] val;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc;
  int unsigned n_checks;
  int unsigned n_fail;
  logic [31:0] a_word[NCH];
  logic [31:0] b_word[NCH];
  logic [31:0] a7;
  logic [31:0] b1;
  logic [31:0] snap1;
  logic [31:0] snapv;

  function automatic logic [81:0] observed();
    return {gpio_dataA, gpio_dataB, addr_hit, snap_valid, snap_count};
  endfunction

  task automatic check(input string tag, input logic [81:0] obs, input logic [81:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed A=%h B=%h hit=%b sv=%b cnt=%0d, expected A=%h B=%h hit=%b sv=%b cnt=%0d",
             tag, obs[81:50], obs[49:18], obs[17], obs[16], obs[15:0],
             exp[81:50], exp[49:18], exp[17], exp[16], exp[15:0]);
    end
  endtask

  task automatic expect_at(input int unsigned d, input string tag, input logic [31:0] a,
                           input logic [31:0] b, input logic hit, input logic sv, input logic [15:0] cnt);
    exp_t e;
    e.tag = tag;
    e.due = cyc + d;
    e.val = {a, b, hit, sv, cnt};
    sb.push_back(e);
  endtask

  task automatic drive();
    for (int k = 0; k < int'(NCH); k++) begin
      ch_a[k*DW +: DW] = a_word[k];
      ch_b[k*DW +: DW] = b_word[k];
    end
  endtask

  // One clock: sample 1 ns after the edge, retire due expectations, update ramp.
  task automatic tick_clk();
    @(posedge aclk);
    #1;
    cyc++;
    for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        check(sb[i].tag, observed(), sb[i].val);
        sb.delete(i);
      end
    end
    a_word[1] = RAMP + cyc;
    drive();
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick_clk();
  endtask

  initial begin
    cyc      = 0;
    n_checks = 0;
    n_fail   = 0;
    for (int k = 0; k < int'(NCH); k++) begin
      a_word[k] = 32'hA000_0000 + 32'(k) * 32'h0101;
      b_word[k] = 32'hB000_0000 + 32'(k);
    end
    a_word[2]   = 32'h1111;
    b_word[2]   = 32'h2222;
    a7          = a_word[7];
    b1          = b_word[1];
    snap1       = 32'h8000_0000 | 32'd100002;
    snapv       = 32'h8000_0000 | 32'd199997;
    aresetn     = 1'b0;
    config_addr = 32'd100003;
    drive();

    // Held in reset: everything zero.
    for (int i = 0; i < 3; i++) begin
      expect_at(1, "reset_hold", 0, 0, 0, 0, 0);
      tick_clk();
    end

    // Release; channel 2 appears two cycles later.
    aresetn = 1'b1;
    expect_at(2, "release_ch2", 32'h1111, 32'h2222, 1, 0, 0);
    run(2);

    // Live change to the last channel: old data for one more cycle.
    config_addr = 32'd100008;
    expect_at(1, "live_old", 32'h1111, 32'h2222, 1, 0, 0);
    expect_at(2, "live_ch7", a7, b_word[7], 1, 0, 0);
    run(2);

    // One past the window: liveness pattern.
    config_addr = 32'd100009;
    expect_at(1, "unmapped_lag", a7, b_word[7], 1, 0, 0);
    expect_at(2, "unmapped_1", a7 + 1, a7 + 13, 0, 0, 0);
    expect_at(3, "unmapped_2", a7 + 2, a7 + 14, 0, 0, 0);
    run(3);

    // Snapshot of ramping channel 1 (write at cycle 10).
    config_addr = snap1;
    expect_at(2, "snap_live", RAMP + cyc + 1, b1, 1, 0, 0);
    expect_at(3, "snap_capture", RAMP + cyc + 2, b1, 1, 1, 1);
    expect_at(4, "snap_held1", RAMP + cyc + 2, b1, 1, 1, 1);
    expect_at(5, "snap_held2", RAMP + cyc + 2, b1, 1, 1, 1);
    expect_at(6, "snap_held3", RAMP + cyc + 2, b1, 1, 1, 1);
    expect_at(7, "snap_rewrite1", RAMP + cyc + 2, b1, 1, 1, 1);
    expect_at(8, "snap_rewrite2", RAMP + cyc + 2, b1, 1, 1, 1);
    run(5);
    config_addr = snap1;
    run(2);

    // Back to live on the same channel.
    config_addr = 32'd100002;
    expect_at(1, "unsnap_lag", RAMP + cyc - 5, b1, 1, 1, 1);
    expect_at(2, "unsnap_live", RAMP + cyc + 1, b1, 1, 0, 1);
    expect_at(3, "unsnap_ramp", RAMP + cyc + 2, b1, 1, 0, 1);
    run(3);

    // Timing reset for five cycles, then timing test.
    config_addr = 32'd102000;
    expect_at(2, "treset", 0, 0, 1, 0, 1);
    run(5);
    config_addr = 32'd101999;
    expect_at(1, "treset_last", 0, 0, 1, 0, 1);
    expect_at(2, "ttest_0", 0, 0, 1, 0, 1);
    expect_at(3, "ttest_1", 1, 0, 1, 0, 1);
    expect_at(4, "ttest_2", 2, 1, 1, 0, 1);
    expect_at(5, "ttest_3", 3, 2, 1, 0, 1);
    run(5);

    // Version, then snapshot of the version address.
    config_addr = 32'd199997;
    expect_at(2, "version", VA, VB, 1, 0, 1);
    run(2);
    config_addr = snapv;
    expect_at(2, "ver_live", VA, VB, 1, 0, 1);
    expect_at(3, "ver_capture", VA, VB, 1, 1, 2);
    expect_at(4, "ver_held", VA, VB, 1, 1, 2);
    run(4);

    // Asynchronous reset while HELD.
    #2;
    aresetn = 1'b0;
    #1;
    check("async_reset", observed(), 82'd0);
    expect_at(1, "reset_again", 0, 0, 0, 0, 0);
    run(1);

    n_checks++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d pending, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
